// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and helpers for the sequential ALU (alu_seq) and
//             its shift-add multiplier (alu_mul_seq).
//  Contents : op_t    - 3-bit operation code (ADD..MUL)
//             state_t - top-level sequencing state (IDLE / MUL)
//             cnt_w() - width of a counter able to hold 0..width
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_ADC = 3'd2,
        OP_SBC = 3'd3,
        OP_SHR = 3'd4,
        OP_AND = 3'd5,
        OP_XOR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_seq
//  Purpose  : Unsigned shift-add multiplier, one multiplier bit per cycle,
//             LSB first, WIDTH iterations.
//  Ports    : clk, reset      - clock / async active-high reset
//             go              - load a, b and begin (ignored while busy)
//             a, b            - multiplicand / multiplier
//             busy            - iterations in progress
//             last            - current cycle performs the final iteration
//             prod            - accumulator including the current iteration;
//                               holds the full product while last=1
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int         c_CW   = cnt_w(WIDTH);
    localparam [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    logic                 r_busy;
    logic [c_CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    // prod is combinational so the top can capture the finished product on
    // the same edge that retires the final iteration.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign prod       = w_acc_next;
    assign busy       = r_busy;
    assign last       = r_busy && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (go && !r_busy) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : alu_mul_seq
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Parametrised sequential ALU: ADD/SUB/ADC/SBC/SHR/AND/XOR in one
//             cycle, optional WIDTH-cycle unsigned multiply, registered
//             carry/shift/zero flags, tri-state drive onto the data bus.
//  Ports    : clk, reset      - clock / async active-high reset
//             op, start       - operation code / launch (sampled while idle)
//             areg, breg      - operands
//             assertBar       - active-low bus drive enable
//             dbus            - result register or high-Z
//             busy, done      - MUL in progress / completion pulse
//             aIsZero         - combinational areg == 0
//             flagCarry, flagShift, flagZero - registered flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic              start,
    input  logic [WIDTH-1:0]  areg,
    input  logic [WIDTH-1:0]  breg,
    input  logic              assertBar,
    output logic [WIDTH-1:0]  dbus,
    output logic              busy,
    output logic              done,
    output logic              aIsZero,
    output logic              flagCarry,
    output logic              flagShift,
    output logic              flagZero
);

    op_t                 w_op;
    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_result, w_result_nxt;
    logic                r_carry, w_carry_nxt;
    logic                r_shift, w_shift_nxt;
    logic                r_zero, w_zero_nxt;
    logic                r_done, w_done_nxt;

    logic [WIDTH-1:0]    w_bop;
    logic                w_cin;
    logic [WIDTH:0]      w_sum;

    logic                w_mul_go;
    logic                w_mul_busy;
    logic                w_mul_last;
    logic [2*WIDTH-1:0]  w_mul_prod;

    assign w_op = op_t'(op);

    // Shared adder: subtraction is A + ~B + cin, so carry-out = not-borrow.
    always_comb begin
        w_bop = breg;
        w_cin = 1'b0;
        unique case (w_op)
            OP_SUB:  begin w_bop = ~breg; w_cin = 1'b1;    end
            OP_ADC:  begin w_bop = breg;  w_cin = r_carry; end
            OP_SBC:  begin w_bop = ~breg; w_cin = r_carry; end
            default: begin w_bop = breg;  w_cin = 1'b0;    end
        endcase
    end

    assign w_sum = {1'b0, areg} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk   (clk),
                .reset (reset),
                .go    (w_mul_go),
                .a     (areg),
                .b     (breg),
                .busy  (w_mul_busy),
                .last  (w_mul_last),
                .prod  (w_mul_prod)
            );
        end else begin : g_no_mul
            assign w_mul_busy = 1'b0;
            assign w_mul_last = 1'b0;
            assign w_mul_prod = '0;
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_carry_nxt  = r_carry;
        w_shift_nxt  = r_shift;
        w_zero_nxt   = r_zero;
        w_done_nxt   = 1'b0;
        w_mul_go     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_done_nxt = 1'b1;
                    unique case (w_op)
                        OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                            w_result_nxt = w_sum[WIDTH-1:0];
                            w_carry_nxt  = w_sum[WIDTH];
                        end
                        OP_SHR: begin
                            w_result_nxt = {r_shift, areg[WIDTH-1:1]};
                            w_shift_nxt  = areg[0];
                        end
                        OP_AND: w_result_nxt = areg & breg;
                        OP_XOR: w_result_nxt = areg ^ breg;
                        OP_MUL: begin
                            // Without a multiplier MUL retires as a no-op
                            // that still acknowledges with done.
                            if (MUL_EN != 0 && !w_mul_busy) begin
                                w_state_nxt = ST_MUL;
                                w_mul_go    = 1'b1;
                                w_done_nxt  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                    if (w_op != OP_MUL) begin
                        w_zero_nxt = (w_result_nxt == '0);
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_result_nxt = w_mul_prod[WIDTH-1:0];
                    w_carry_nxt  = |w_mul_prod[2*WIDTH-1:WIDTH];
                    w_zero_nxt   = (w_mul_prod[WIDTH-1:0] == '0);
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_shift  <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_carry  <= w_carry_nxt;
            r_shift  <= w_shift_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign dbus      = assertBar ? {WIDTH{1'bz}} : r_result;
    assign busy      = (r_state == ST_MUL);
    assign done      = r_done;
    assign aIsZero   = (areg == '0);
    assign flagCarry = r_carry;
    assign flagShift = r_shift;
    assign flagZero  = r_zero;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=8) with MUL_EN=1 and a
//             second instance with MUL_EN=0, against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    typedef struct {
        int r;
        bit c;
        bit s;
        bit z;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = 3'd0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] areg = 8'd0;
    logic [7:0] breg = 8'd0;
    logic       assertBar = 1'b1;

    wire  [7:0] dbus;
    logic       busy, done, aIsZero, flagCarry, flagShift, flagZero;
    wire  [7:0] dbus1;
    logic       busy1, done1, aIsZero1, flagCarry1, flagShift1, flagZero1;

    int total = 0;
    int bad   = 0;

    mstate_t m;
    mstate_t m1;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start),
        .areg(areg), .breg(breg), .assertBar(assertBar),
        .dbus(dbus), .busy(busy), .done(done), .aIsZero(aIsZero),
        .flagCarry(flagCarry), .flagShift(flagShift), .flagZero(flagZero)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(0)) dut1 (
        .clk(clk), .reset(reset), .op(op), .start(start1),
        .areg(areg), .breg(breg), .assertBar(assertBar),
        .dbus(dbus1), .busy(busy1), .done(done1), .aIsZero(aIsZero1),
        .flagCarry(flagCarry1), .flagShift(flagShift1), .flagZero(flagZero1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model: plain integer arithmetic on 8-bit values.
    function automatic mstate_t model(mstate_t st, int o, int a, int b, bit mul_en);
        mstate_t n;
        int      s;
        int      p;
        n = st;
        case (o)
            0: begin s = a + b;               n.r = s % 256; n.c = (s >= 256); end
            1: begin s = a + (255 - b) + 1;   n.r = s % 256; n.c = (s >= 256); end
            2: begin s = a + b + int'(st.c);  n.r = s % 256; n.c = (s >= 256); end
            3: begin s = a + (255 - b) + int'(st.c); n.r = s % 256; n.c = (s >= 256); end
            4: begin n.r = (st.s ? 128 : 0) + a / 2; n.s = (a % 2) == 1; end
            5: n.r = a & b;
            6: n.r = a ^ b;
            default: begin
                if (!mul_en) return st;
                p = a * b;
                n.r = p % 256;
                n.c = (p / 256) != 0;
            end
        endcase
        n.z = (n.r == 0);
        return n;
    endfunction

    task automatic chk_state(input string tag, input mstate_t e);
        chk({tag, "_res"}, {24'd0, dbus}, e.r);
        chk({tag, "_c"}, {31'd0, flagCarry}, {31'd0, e.c});
        chk({tag, "_s"}, {31'd0, flagShift}, {31'd0, e.s});
        chk({tag, "_z"}, {31'd0, flagZero}, {31'd0, e.z});
    endtask

    // Runs one op on dut; inj >= 0 pulses an ADD start that many cycles into a MUL.
    task automatic run_op(input int o, input int a, input int b, input int inj);
        mstate_t nx;
        int      lat;
        bit      seen;
        @(negedge clk);
        op = 3'(o); areg = 8'(a); breg = 8'(b); start = 1'b1;
        nx = model(m, o, a, b, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 7) begin
            lat = 0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (done) begin
                    seen = 1'b1;
                end else begin
                    chk("mul_busy", {31'd0, busy}, 32'd1);
                    chk("mul_hold", {24'd0, dbus}, m.r);
                    @(negedge clk);
                    if (i == inj) begin
                        op = 3'd0; areg = 8'h55; breg = 8'h11; start = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    @(posedge clk); #1;
                    lat++;
                end
            end
            start = 1'b0;
            chk("mul_latency", lat, 32'd8);
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_low", {31'd0, busy}, 32'd0);
        m = nx;
        chk_state("op", m);
        @(posedge clk); #1;
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    task automatic run_op1(input int o, input int a, input int b);
        @(negedge clk);
        op = 3'(o); areg = 8'(a); breg = 8'(b); start1 = 1'b1;
        m1 = model(m1, o, a, b, 1'b0);
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("nomul_done", {31'd0, done1}, 32'd1);
        chk("nomul_busy", {31'd0, busy1}, 32'd0);
        chk("nomul_res", {24'd0, dbus1}, m1.r);
        chk("nomul_c", {31'd0, flagCarry1}, {31'd0, m1.c});
        chk("nomul_z", {31'd0, flagZero1}, {31'd0, m1.z});
        @(posedge clk); #1;
        chk("nomul_done_clr", {31'd0, done1}, 32'd0);
        chk("nomul_busy2", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        m  = '{0, 1'b0, 1'b0, 1'b0};
        m1 = '{0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dbus_z", {31'd0, (dbus === 8'hzz)}, 32'd1);
        assertBar = 1'b0;
        #1;
        chk_state("rst", m);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_op(0, 8'hFF, 8'h01, -1);
        run_op(1, 8'h05, 8'h07, -1);
        run_op(3, 8'h10, 8'h01, -1);
        run_op(0, 8'h80, 8'h80, -1);
        run_op(2, 8'h01, 8'h01, -1);
        run_op(4, 8'h03, 8'h00, -1);
        run_op(4, 8'h03, 8'h00, -1);
        chk("shr_twice", {24'd0, dbus}, 32'h81);
        run_op(7, 8'h0D, 8'h0B, 3);
        chk("mul_0d_0b", {24'd0, dbus}, 32'h8F);
        run_op(7, 8'h20, 8'h10, -1);
        chk("mul_ovf_c", {31'd0, flagCarry}, 32'd1);
        run_op(5, 8'hF0, 8'h3C, -1);
        run_op(6, 8'hF0, 8'h3C, -1);

        // MUL_EN=0 instance: MUL retires as a 1-cycle no-op
        run_op1(0, 8'h12, 8'h34);
        run_op1(7, 8'h20, 8'h10);
        chk("nomul_unchanged", {24'd0, dbus1}, 32'h46);

        // aIsZero
        @(negedge clk);
        areg = 8'h00; #1;
        chk("aiszero_1", {31'd0, aIsZero}, 32'd1);
        areg = 8'h40; #1;
        chk("aiszero_0", {31'd0, aIsZero}, 32'd0);

        // Randomized ops
        for (int k = 0; k < 40; k++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        // Reset in the middle of a MUL
        @(negedge clk);
        op = 3'd7; areg = 8'hFF; breg = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m = '{0, 1'b0, 1'b0, 1'b0};
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk_state("mrst", m);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("mrst_no_done", {31'd0, done}, 32'd0);
            chk("mrst_no_busy", {31'd0, busy}, 32'd0);
        end
        assertBar = 1'b1; #1;
        chk("mrst_dbus_z", {31'd0, (dbus === 8'hzz)}, 32'd1);
        assertBar = 1'b0; #1;
        chk("mrst_dbus_0", {24'd0, dbus}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_seq
`default_nettype wire
